alu_mem_unit: RTL and testbench
===============================

Name: alu_mem_unit

Overview:
- Execute/memory slice of the single-cycle 64-bit LEGv8 datapath.
- Decodes ALUOp plus the 11-bit opcode into a 4-bit ALU control code, computes the 64-bit ALU result and the zero flag, and addresses a byte-addressed data memory with that result.
- Sits between the register file / immediate mux and the MemToReg write-back mux.

Parameters:
- MEM_BYTES, 1024, data memory size in bytes; must be a power of two and at least 8.
- ADDR_W, 64, width of the address and data paths; fixed at 64.

Ports:
- CLK  input  1  system clock; memory writes occur on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- ALUOp  input  2  class from main control: 00 load/store, 01 CBZ, 10 R-type, 11 reserved.
- Opcode  input  11  instruction bits [31:21].
- BusA  input  64  ALU operand A (register Rn).
- ALUInB  input  64  ALU operand B (output of the ALUSrc mux).
- WriteData  input  64  store data (register-file busB, not ALUInB).
- MemRead  input  1  read enable.
- MemWrite  input  1  write enable.
- ALUCtrl  output  4  decoded ALU control code.
- ALUResult  output  64  ALU result; also the memory byte address.
- Zero  output  1  1 when ALUResult == 0.
- ReadData  output  64  memory read data.

Behaviour:
- ALU control decode is combinational:
  - ALUOp 00 -> 0010 (ADD).
  - ALUOp 01 -> 0111 (pass B).
  - ALUOp 10 decodes Opcode: 10001011000 ADD -> 0010; 11001011000 SUB -> 0110; 10001010000 AND -> 0000; 10101010000 ORR -> 0001.
  - Any other opcode with ALUOp 10, and ALUOp 11 -> 1111.
- ALU is combinational; arithmetic is modulo 2^64 with no carry/overflow outputs:
  - 0000 A&B; 0001 A|B; 0010 A+B; 0110 A-B; 0111 B.
  - Any other code -> 0.
- Zero = (ALUResult == 0), combinational.
- Memory storage: MEM_BYTES bytes. Effective address = ALUResult modulo MEM_BYTES (low log2(MEM_BYTES) bits); higher bits are ignored.
- Byte order is big-endian: the doubleword at address a is byte[a] (bits 63:56) through byte[a+7] (bits 7:0). Each byte index wraps modulo MEM_BYTES. Unaligned addresses are legal.
- Read is combinational: ReadData = doubleword at the effective address when MemRead=1, else 64'h0.
- Write: on rising CLK with MemWrite=1 and Reset=0, all 8 bytes of WriteData are stored big-endian at the effective address.
- Simultaneous MemRead and MemWrite: ReadData shows the old contents until the edge, then the new contents.
- Reset asserted (asynchronous, any time including mid-cycle):
  - All memory bytes clear to 0 immediately; ReadData therefore reads 0.
  - Writes are blocked while Reset is high.
  - ALU and ALUControl are pure combinational logic and are unaffected by reset.
- No internal state other than the memory array; single-cycle, zero latency except the write edge.

Decomposition:
- Shared package holds:
  - ALUCtrl codes: CTRL_AND, CTRL_ORR, CTRL_ADD, CTRL_SUB, CTRL_PASSB, CTRL_INVALID.
  - ALUOp encodings.
  - The four R-type opcode constants.
- Top level integrates the ALU control decode and the ALU as combinational logic.
- One natural sub-module: data_mem_bytes (byte array with big-endian 64-bit read/write, async clear).

Test Plan:
- ALUOp=10, Opcode=10001011000, A=5, B=7 -> ALUCtrl=0010, ALUResult=12, Zero=0.
- SUB with A=B=64'hDEADBEEF -> ALUCtrl=0110, ALUResult=0, Zero=1. SUB with A=0, B=1 -> ALUResult=64'hFFFFFFFFFFFFFFFF.
- AND/ORR with A=64'hF0F0, B=64'h0FF0 -> AND 64'h00F0, ORR 64'hFFF0. ALUOp=01 with B=0 -> Zero=1; B=3 -> ALUResult=3. ALUOp=11 -> ALUCtrl=1111, ALUResult=0.
- Store: ALUOp=00, A=8, B=0, WriteData=64'h0123456789ABCDEF, MemWrite=1, one CLK rising edge. Then MemRead=1 at the same address -> ReadData=64'h0123456789ABCDEF. Read at address 9 -> 64'h23456789ABCDEF00. MemRead=0 -> ReadData=0.
- Wrap: write 64'h1122334455667788 at address MEM_BYTES-4 -> bytes 0..3 hold 55,66,77,88. Address MEM_BYTES+8 aliases address 8.
- Reset: after the writes above, pulse Reset mid-cycle with no clock edge -> ReadData=0 immediately at every tested address. A write attempted while Reset is high is not stored.

Source files
------------

// File: rtl/alu_mem_unit_pkg.sv
// Shared encodings for the LEGv8 execute/memory slice: ALU control codes,
// ALUOp classes from main control and the R-type opcodes the decoder knows.
package alu_mem_unit_pkg;

    // 4-bit ALU control codes driven by the ALU control decoder
    typedef enum logic [3:0] {
        CTRL_AND     = 4'b0000,
        CTRL_ORR     = 4'b0001,
        CTRL_ADD     = 4'b0010,
        CTRL_SUB     = 4'b0110,
        CTRL_PASSB   = 4'b0111,
        CTRL_INVALID = 4'b1111
    } alu_ctrl_e;

    // Instruction class supplied by the main control unit
    typedef enum logic [1:0] {
        ALUOP_LDST  = 2'b00,
        ALUOP_CBZ   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_e;

    // Instruction bits [31:21] of the supported R-type operations
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

endpackage

// File: rtl/alu_mem_unit_data_mem_bytes.sv
// Byte-addressed data memory with big-endian 64-bit access. Reads are
// combinational, writes happen on the rising clock edge, and reset clears
// every byte asynchronously. Byte indices wrap around the array end.
module alu_mem_unit_data_mem_bytes #(
    parameter int MEM_BYTES = 1024
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [$clog2(MEM_BYTES)-1:0] i_addr,
    input  logic                         i_re,
    input  logic                         i_we,
    input  logic [63:0]                  i_wdata,
    output logic [63:0]                  o_rdata
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]    r_mem [MEM_BYTES];
    logic [AW-1:0] w_byteIdx [8];

    // Index of each of the eight bytes, wrapping modulo the array size
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_byteIdx[k] = i_addr + AW'(k);
        end
    end

    // Big-endian read: lowest address lands in the most significant byte
    always_comb begin
        o_rdata = '0;
        if (i_re) begin
            for (int k = 0; k < 8; k++) begin
                o_rdata[63-8*k -: 8] = r_mem[w_byteIdx[k]];
            end
        end
    end

    // Async clear of the whole array, otherwise big-endian store on write
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            for (int k = 0; k < 8; k++) begin
                r_mem[w_byteIdx[k]] <= i_wdata[63-8*k -: 8];
            end
        end
    end

endmodule

// File: rtl/alu_mem_unit.sv
// Execute/memory slice of the single-cycle LEGv8 datapath: ALU control
// decode, 64-bit ALU with zero flag, and the data memory addressed by the
// ALU result. Only the memory holds state; everything else is combinational.
module alu_mem_unit
    import alu_mem_unit_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 64
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [1:0]        ALUOp,
    input  logic [10:0]       Opcode,
    input  logic [ADDR_W-1:0] BusA,
    input  logic [ADDR_W-1:0] ALUInB,
    input  logic [ADDR_W-1:0] WriteData,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [3:0]        ALUCtrl,
    output logic [ADDR_W-1:0] ALUResult,
    output logic              Zero,
    output logic [ADDR_W-1:0] ReadData
);

    localparam int AW = $clog2(MEM_BYTES);

    logic [3:0]        w_aluCtrl;
    logic [ADDR_W-1:0] w_aluResult;

    // Map the instruction class and R-type opcode onto an ALU control code
    always_comb begin
        w_aluCtrl = CTRL_INVALID;
        case (ALUOp)
            ALUOP_LDST: w_aluCtrl = CTRL_ADD;
            ALUOP_CBZ:  w_aluCtrl = CTRL_PASSB;
            ALUOP_RTYPE: begin
                case (Opcode)
                    OPC_ADD: w_aluCtrl = CTRL_ADD;
                    OPC_SUB: w_aluCtrl = CTRL_SUB;
                    OPC_AND: w_aluCtrl = CTRL_AND;
                    OPC_ORR: w_aluCtrl = CTRL_ORR;
                    default: w_aluCtrl = CTRL_INVALID;
                endcase
            end
            default: w_aluCtrl = CTRL_INVALID;
        endcase
    end

    // 64-bit ALU, arithmetic wraps modulo 2^64; unknown codes yield zero
    always_comb begin
        w_aluResult = '0;
        case (w_aluCtrl)
            CTRL_AND:   w_aluResult = BusA & ALUInB;
            CTRL_ORR:   w_aluResult = BusA | ALUInB;
            CTRL_ADD:   w_aluResult = BusA + ALUInB;
            CTRL_SUB:   w_aluResult = BusA - ALUInB;
            CTRL_PASSB: w_aluResult = ALUInB;
            default:    w_aluResult = '0;
        endcase
    end

    assign ALUCtrl   = w_aluCtrl;
    assign ALUResult = w_aluResult;
    assign Zero      = (w_aluResult == '0);

    // Only the low address bits select a byte; upper bits alias
    alu_mem_unit_data_mem_bytes #(
        .MEM_BYTES (MEM_BYTES)
    ) u_dataMem (
        .i_clk   (CLK),
        .i_rst   (Reset),
        .i_addr  (w_aluResult[AW-1:0]),
        .i_re    (MemRead),
        .i_we    (MemWrite),
        .i_wdata (WriteData),
        .o_rdata (ReadData)
    );

endmodule

// File: tb/tb_alu_mem_unit.sv
// Self-checking bench for alu_mem_unit: a table of ALU/decode vectors plus
// hand-written memory sequences (store/load, unaligned, wrap, alias, reset).
// Expected values are queued when stimulus is driven and popped on compare.
module tb_alu_mem_unit;

    localparam int MEM_BYTES = 1024;

    logic        clk;
    logic        reset;
    logic [1:0]  aluOp;
    logic [10:0] opcode;
    logic [63:0] busA;
    logic [63:0] aluInB;
    logic [63:0] writeData;
    logic        memRead;
    logic        memWrite;
    logic [3:0]  aluCtrl;
    logic [63:0] aluResult;
    logic        zero;
    logic [63:0] readData;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  aluOp;
        logic [10:0] opcode;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  expCtrl;
        logic [63:0] expRes;
        logic        expZero;
    } aluVec_t;

    aluVec_t     vecs [$];
    aluVec_t     expQ [$];
    logic [63:0] readQ [$];

    alu_mem_unit #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (64)
    ) dut (
        .CLK       (clk),
        .Reset     (reset),
        .ALUOp     (aluOp),
        .Opcode    (opcode),
        .BusA      (busA),
        .ALUInB    (aluInB),
        .WriteData (writeData),
        .MemRead   (memRead),
        .MemWrite  (memWrite),
        .ALUCtrl   (aluCtrl),
        .ALUResult (aluResult),
        .Zero      (zero),
        .ReadData  (readData)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and count it
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drive the ALU-side inputs
    task automatic applyStimulus(input logic [1:0] op, input logic [10:0] opc,
                                 input logic [63:0] a, input logic [63:0] b);
        aluOp  = op;
        opcode = opc;
        busA   = a;
        aluInB = b;
    endtask

    // Queue an expected read value, let the combinational path settle, compare
    task automatic expectRead(input string name, input logic [63:0] exp);
        readQ.push_back(exp);
        #1;
        checkOutput(name, readData, readQ.pop_front());
    endtask

    function automatic aluVec_t mkVec(input logic [1:0] op, input logic [10:0] opc,
                                      input logic [63:0] a, input logic [63:0] b,
                                      input logic [3:0] c, input logic [63:0] r,
                                      input logic z);
        aluVec_t v;
        v.aluOp = op; v.opcode = opc; v.a = a; v.b = b;
        v.expCtrl = c; v.expRes = r; v.expZero = z;
        return v;
    endfunction

    initial begin
        aluVec_t cur;
        aluVec_t exp;

        $display("[TB] start");
        reset     = 1'b1;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        writeData = '0;
        applyStimulus(2'b00, 11'h0, 64'h0, 64'h0);

        vecs.push_back(mkVec(2'b10, 11'b10001011000, 64'd5, 64'd7, 4'b0010, 64'd12, 1'b0));
        vecs.push_back(mkVec(2'b10, 11'b11001011000, 64'hDEADBEEF, 64'hDEADBEEF, 4'b0110, 64'd0, 1'b1));
        vecs.push_back(mkVec(2'b10, 11'b11001011000, 64'd0, 64'd1, 4'b0110, 64'hFFFFFFFFFFFFFFFF, 1'b0));
        vecs.push_back(mkVec(2'b10, 11'b10001010000, 64'hF0F0, 64'h0FF0, 4'b0000, 64'h00F0, 1'b0));
        vecs.push_back(mkVec(2'b10, 11'b10101010000, 64'hF0F0, 64'h0FF0, 4'b0001, 64'hFFF0, 1'b0));
        vecs.push_back(mkVec(2'b01, 11'b10001011000, 64'd9, 64'd0, 4'b0111, 64'd0, 1'b1));
        vecs.push_back(mkVec(2'b01, 11'b00000000000, 64'd9, 64'd3, 4'b0111, 64'd3, 1'b0));
        vecs.push_back(mkVec(2'b11, 11'b10001011000, 64'd5, 64'd7, 4'b1111, 64'd0, 1'b1));
        vecs.push_back(mkVec(2'b10, 11'b11111111111, 64'd5, 64'd7, 4'b1111, 64'd0, 1'b1));
        vecs.push_back(mkVec(2'b00, 11'b11001011000, 64'd8, 64'd16, 4'b0010, 64'd24, 1'b0));
        vecs.push_back(mkVec(2'b10, 11'b10001011000, 64'hFFFFFFFFFFFFFFFF, 64'd1, 4'b0010, 64'd0, 1'b1));
        vecs.push_back(mkVec(2'b10, 11'b10001010000, 64'hAAAA0000FFFF5555, 64'h5555FFFF0000AAAA, 4'b0000, 64'd0, 1'b1));

        // Memory must read zero straight out of reset
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b0;
        memRead = 1'b1;
        applyStimulus(2'b00, 11'h0, 64'd0, 64'd0);
        expectRead("reset_read0", 64'h0);
        memRead = 1'b0;

        // ALU / decode table, unaffected by memory traffic
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            cur = vecs[i];
            applyStimulus(cur.aluOp, cur.opcode, cur.a, cur.b);
            expQ.push_back(cur);
            #1;
            exp = expQ.pop_front();
            checkOutput($sformatf("vec%0d_ctrl", i), {60'h0, aluCtrl}, {60'h0, exp.expCtrl});
            checkOutput($sformatf("vec%0d_res", i), aluResult, exp.expRes);
            checkOutput($sformatf("vec%0d_zero", i), {63'h0, zero}, {63'h0, exp.expZero});
        end

        // Store at 8 with read enabled: old data before the edge, new after
        @(negedge clk);
        applyStimulus(2'b00, 11'h0, 64'd8, 64'd0);
        writeData = 64'h0123456789ABCDEF;
        memWrite  = 1'b1;
        memRead   = 1'b1;
        expectRead("store_before_edge", 64'h0);
        @(posedge clk);
        expectRead("store_after_edge", 64'h0123456789ABCDEF);
        @(negedge clk);
        memWrite = 1'b0;
        expectRead("load_addr8", 64'h0123456789ABCDEF);
        applyStimulus(2'b00, 11'h0, 64'd9, 64'd0);
        expectRead("load_unaligned9", 64'h23456789ABCDEF00);
        memRead = 1'b0;
        expectRead("memread_off", 64'h0);

        // Store straddling the top of memory wraps into bytes 0..3
        @(negedge clk);
        applyStimulus(2'b00, 11'h0, 64'(MEM_BYTES - 4), 64'd0);
        writeData = 64'h1122334455667788;
        memWrite  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        memWrite = 1'b0;
        memRead  = 1'b1;
        expectRead("wrap_readback", 64'h1122334455667788);
        applyStimulus(2'b00, 11'h0, 64'd0, 64'd0);
        expectRead("wrap_low_bytes", 64'h5566778800000000);
        applyStimulus(2'b00, 11'h0, 64'(MEM_BYTES), 64'd8);
        expectRead("alias_addr8", 64'h0123456789ABCDEF);

        // Reset mid-cycle clears memory at once; writes under reset are dropped
        @(negedge clk);
        #2;
        reset = 1'b1;
        applyStimulus(2'b00, 11'h0, 64'd8, 64'd0);
        expectRead("rst_addr8", 64'h0);
        applyStimulus(2'b00, 11'h0, 64'd0, 64'd0);
        expectRead("rst_addr0", 64'h0);
        applyStimulus(2'b00, 11'h0, 64'(MEM_BYTES - 4), 64'd0);
        expectRead("rst_addrTop", 64'h0);
        applyStimulus(2'b00, 11'h0, 64'd16, 64'd0);
        writeData = 64'hCAFEF00DDEADBEEF;
        memWrite  = 1'b1;
        #1;
        checkOutput("rst_alu_unaffected", aluResult, 64'd16);
        @(posedge clk);
        expectRead("rst_write_blocked", 64'h0);
        @(negedge clk);
        memWrite = 1'b0;
        reset    = 1'b0;
        expectRead("post_rst_addr16", 64'h0);
        applyStimulus(2'b00, 11'h0, 64'd8, 64'd0);
        expectRead("post_rst_addr8", 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
